uart_rx: RTL

// - UART receiver. Companion of the transmitter in the UART-AXI IP.
// - Oversamples the asynchronous uart_rxd line with the system clock and verifies the start bit.
// - Samples PAYLOAD_BITS data bits LSB-first at mid-bit, then checks STOP_BITS stop bits.
// - Presents each received word to the AXI register side as a one-cycle valid pulse, or flags a framing error.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings and bit-timing helpers.
package uart_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Wide enough for up to 15 payload bits and 2 stop bits.
  localparam int unsigned BIT_CNT_W = 4;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned cycle_cnt_w(input int unsigned n);
    return 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to the idle-high level.
module uart_rx_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit check, mid-bit LSB-first data sampling,
// stop-bit check, and one-cycle valid / framing-error / break pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int unsigned N    = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF = N / 2;
  localparam int unsigned CW   = cycle_cnt_w(N);

  localparam logic [CW-1:0]        CNT_LAST      = CW'(N - 1);
  localparam logic [CW-1:0]        CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST     = BIT_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST     = BIT_CNT_W'(STOP_BITS - 1);

  logic rxd_s;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (uart_rxd),
    .q_o    (rxd_s)
  );

  logic [1:0]              state_q,    state_d;
  logic [CW-1:0]           cnt_q,      cnt_d;
  logic [BIT_CNT_W-1:0]    bit_q,      bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q,    shift_d;
  logic                    stop_err_q, stop_err_d;
  // armed_q gates new starts: low after reset or a break until the line is seen high.
  logic                    armed_q,    armed_d;
  logic [1:0]              warm_q,     warm_d;
  logic                    valid_q,    valid_d;
  logic                    ferr_q,     ferr_d;
  logic                    brk_q,      brk_d;
  logic [PAYLOAD_BITS-1:0] data_q,     data_d;
  logic                    frame_bad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      stop_err_q <= 1'b0;
      armed_q    <= 1'b0;
      warm_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      stop_err_q <= stop_err_d;
      armed_q    <= armed_d;
      warm_q     <= warm_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_err_d = stop_err_q;
    armed_d    = armed_q;
    warm_d     = {warm_q[0], 1'b1};
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    brk_d      = 1'b0;
    data_d     = data_q;
    frame_bad  = stop_err_q | ~rxd_s;

    // The synchroniser holds its reset value for two cycles; ignore it until real data arrives.
    if (warm_q[1] && rxd_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (uart_rx_en && armed_q && !rxd_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxd_s ? ST_IDLE : ST_RECV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RECV: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1] = rxd_s;
          if (bit_q == DATA_LAST) begin
            state_d    = ST_STOP;
            bit_d      = '0;
            stop_err_d = 1'b0;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            if (frame_bad) begin
              ferr_d = 1'b1;
              if (shift_q == '0) begin
                brk_d   = 1'b1;
                armed_d = 1'b0;
              end
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            bit_d      = bit_q + BIT_CNT_W'(1);
            stop_err_d = frame_bad;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Disabling the receiver abandons any frame in flight without reporting it.
    if (!uart_rx_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      brk_d   = 1'b0;
      data_d  = data_q;
    end
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_break     = brk_q;

endmodule
